// File: rtl/ext_arb.sv
// ext_arb: two-requester immediate-extension unit with a one-entry output register.
// Each accepted request has its 16-bit immediate extended according to its op, and
// the result is registered for the consumer on the following cycle.
// Build option EXT_ARB_RR_EN: round-robin arbitration between the two requesters.
// When it is undefined, requester 0 always wins, and there is no priority state.
module ext_arb
`ifdef EXT_ARB_RR_EN
#(
    parameter bit RR_INIT = 1'b0
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_imm,
    input  logic [15:0] req1_imm,
    input  logic [1:0]  req0_eop,
    input  logic [1:0]  req1_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ext,
    output logic        out_src
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_ext;
    logic        r_src;
    logic        w_slot_ok;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic [15:0] w_imm;
    logic [1:0]  w_eop;
    logic [31:0] w_ext;

    // Extension of an unsigned 16-bit immediate by op code.
    function automatic logic [31:0] f_ext(input logic [15:0] imm, input logic [1:0] eop);
        case (eop)
            2'd0:    f_ext = {16'h0000, imm};
            2'd1:    f_ext = {{16{imm[15]}}, imm};
            2'd2:    f_ext = {imm, 16'h0000};
            default: f_ext = {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    // The result slot can take a new entry when it is empty or is draining this cycle.
    // Readies are also held low while reset is asserted.
    assign w_slot_ok = reset & ((r_state == S_EMPTY) | out_ready);

`ifdef EXT_ARB_RR_EN
    logic r_prio;  // index of the requester that wins a tie

    // The tie goes to the priority holder. A single valid requester wins outright.
    always_comb begin
        w_gnt0 = w_slot_ok & req0_valid & (~req1_valid | ~r_prio);
        w_gnt1 = w_slot_ok & req1_valid & (~req0_valid |  r_prio);
    end

    // After each accept, priority passes to the requester that was not granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_prio <= RR_INIT;
        else if (w_accept)
            r_prio <= w_gnt0;
    end
`else
    // Fixed priority: requester 0 always wins.
    always_comb begin
        w_gnt0 = w_slot_ok & req0_valid;
        w_gnt1 = w_slot_ok & req1_valid & ~req0_valid;
    end
`endif

    assign w_accept   = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Operand mux feeding the extender. Its output is captured only in r_ext,
    // so there is no combinational path from the request fields to the outputs.
    always_comb begin
        w_imm = w_gnt1 ? req1_imm : req0_imm;
        w_eop = w_gnt1 ? req1_eop : req0_eop;
        w_ext = f_ext(w_imm, w_eop);
    end

    // Slot occupancy: an accept fills the slot, and a consume with no accept empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_EMPTY;
        else if (w_accept)
            r_state <= S_FULL;
        else if (r_state == S_FULL && out_ready)
            r_state <= S_EMPTY;
    end

    // Result capture on accept. The result holds otherwise, so it stays stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext <= 32'h0;
            r_src <= 1'b0;
        end else if (w_accept) begin
            r_ext <= w_ext;
            r_src <= w_gnt1;
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_ext   = r_ext;
    assign out_src   = r_src;

endmodule

// File: tb/tb_ext_arb.sv
// Self-checking bench for ext_arb. Inputs are driven on the falling edge.
// Readies are sampled 1ns later, and registered outputs 1ns after the rising edge.
// Expected values come from a transaction-level model of the result slot.
module tb_ext_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_imm, req1_imm;
    logic [1:0]  req0_eop, req1_eop;
    logic        out_valid, out_ready;
    logic [31:0] out_ext;
    logic        out_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef EXT_ARB_RR_EN
    ext_arb #(.RR_INIT(1'b0)) dut (
`else
    ext_arb dut (
`endif
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_imm(req0_imm), .req1_imm(req1_imm),
        .req0_eop(req0_eop), .req1_eop(req1_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ext(out_ext), .out_src(out_src)
    );

    // Reference model state: slot occupancy, held result, and the tie-winner index.
    bit          m_full;
    logic [31:0] m_ext;
    bit          m_src;
    bit          m_prio;

    function automatic logic [31:0] ext_ref(input int unsigned imm, input int unsigned eop);
        logic [31:0] sx;
        sx = (imm >= 32768) ? (imm + 32'hFFFF0000) : imm;
        case (eop)
            0: return imm;
            1: return sx;
            2: return imm * 65536;
            default: return sx * 4;
        endcase
    endfunction

    // Which requester is granted: bit0 = req0, bit1 = req1, 0 = none.
    function automatic logic [1:0] exp_grant();
        if (!reset) return 2'b00;
        if (m_full && !out_ready) return 2'b00;
        if (req0_valid && req1_valid) begin
`ifdef EXT_ARB_RR_EN
            return m_prio ? 2'b10 : 2'b01;
`else
            return 2'b01;
`endif
        end
        return {req1_valid, req0_valid};
    endfunction

    task automatic model_reset();
        m_full = 0; m_ext = 32'h0; m_src = 0; m_prio = 0;
    endtask

    task automatic drive(input bit v0, input bit v1, input logic [15:0] i0, input logic [15:0] i1,
                         input logic [1:0] e0, input logic [1:0] e1, input bit ordy);
        @(negedge clk);
        req0_valid = v0; req1_valid = v1; req0_imm = i0; req1_imm = i1;
        req0_eop = e0; req1_eop = e1; out_ready = ordy;
        #1;
    endtask

    // Advance one clock and update the model from the inputs that were stable before the edge.
    task automatic tick();
        logic [1:0] g;
        g = exp_grant();
        @(posedge clk);
        if (g != 2'b00) begin
            m_full = 1;
            m_src  = g[1];
            m_ext  = g[1] ? ext_ref(req1_imm, req1_eop) : ext_ref(req0_imm, req0_eop);
            m_prio = g[0];
        end else if (out_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1; req1_valid = 1; req0_imm = 16'h1234; req1_imm = 16'h5678;
        req0_eop = 0; req1_eop = 0; out_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_ext !== 32'h0) begin errors++; $display("FAIL reset_ext got %h want 0", out_ext); end
        checks++;
        if (out_src !== 1'b0) begin errors++; $display("FAIL reset_src got %b want 0", out_src); end
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_ext_ops();
        logic [31:0] want [4];
        want[0] = 32'h0000FFFB; want[1] = 32'hFFFFFFFB; want[2] = 32'hFFFB0000; want[3] = 32'hFFFFFFEC;
        for (int e = 0; e < 4; e++) begin
            drive(1, 0, 16'hFFFB, 16'h0, 2'(e), 2'd0, 1);
            checks++;
            if (req0_ready !== 1'b1) begin errors++; $display("FAIL ext_ready%0d got %b want 1", e, req0_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ext !== want[e] || out_src !== 1'b0) begin
                errors++;
                $display("FAIL ext_op%0d got v=%b ext=%h src=%b want v=1 ext=%h src=0", e, out_valid, out_ext, out_src, want[e]);
            end
        end
        drive(0, 0, 16'h0, 16'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_arb();
        bit want_src [4];
        bit saw_r1;
        reset = 1'b0; model_reset();
        @(negedge clk); reset = 1'b1;
        saw_r1 = 0;
`ifdef EXT_ARB_RR_EN
        want_src[0] = 0; want_src[1] = 1; want_src[2] = 0; want_src[3] = 1;
`else
        for (int k = 0; k < 4; k++) want_src[k] = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 16'(k), 16'(16'h100 + k), 2'd0, 2'd0, 1);
            if (req1_ready) saw_r1 = 1;
            checks++;
            if ((req0_ready ^ req1_ready) !== 1'b1) begin
                errors++; $display("FAIL arb_one_accept%0d got r0=%b r1=%b want exactly one", k, req0_ready, req1_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== want_src[k]) begin
                errors++; $display("FAIL arb_src%0d got v=%b src=%b want v=1 src=%b", k, out_valid, out_src, want_src[k]);
            end
        end
`ifndef EXT_ARB_RR_EN
        checks++;
        if (saw_r1) begin errors++; $display("FAIL arb_fixed_r1 got req1_ready=1 want never"); end
`endif
        drive(0, 0, 16'h0, 16'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_stall();
        drive(0, 1, 16'h0, 16'h8000, 2'd0, 2'd1, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 16'hAAAA, 16'h5555, 2'd3, 2'd2, 0);
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                errors++; $display("FAIL stall_ready%0d got %b want 00", k, {req1_ready, req0_ready});
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ext !== 32'hFFFF8000 || out_src !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d got v=%b ext=%h src=%b want v=1 ext=ffff8000 src=1", k, out_valid, out_ext, out_src);
            end
        end
        drive(0, 0, 16'h0, 16'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset_mid();
        // Make requester 1 hold priority (RR) before the reset, so its restoration shows.
        drive(1, 0, 16'h0042, 16'h0, 2'd0, 2'd0, 1);
        tick();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ext !== 32'h0) begin
            errors++; $display("FAIL midreset got v=%b ext=%h want v=0 ext=0", out_valid, out_ext);
        end
        model_reset();
        @(negedge clk); reset = 1'b1;
        drive(1, 1, 16'h0007, 16'h0009, 2'd0, 2'd0, 1);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL midreset_first got %b want 01", {req1_ready, req0_ready});
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ext !== 32'h7 || out_src !== 1'b0) begin
            errors++; $display("FAIL midreset_result got v=%b ext=%h src=%b want v=1 ext=7 src=0", out_valid, out_ext, out_src);
        end
    endtask

    task automatic test_random();
        logic [1:0] g;
        for (int k = 0; k < 300; k++) begin
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  2'($urandom), 2'($urandom), bit'($urandom_range(0, 3) != 0));
            g = exp_grant();
            checks++;
            if ({req1_ready, req0_ready} !== g) begin
                errors++; $display("FAIL rand_ready%0d got %b want %b", k, {req1_ready, req0_ready}, g);
            end
            tick();
            checks++;
            if (out_valid !== m_full || (m_full && (out_ext !== m_ext || out_src !== m_src))) begin
                errors++;
                $display("FAIL rand_out%0d got v=%b ext=%h src=%b want v=%b ext=%h src=%b", k, out_valid, out_ext, out_src, m_full, m_ext, m_src);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_ops();
        test_arb();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
